// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter_pkg
// Purpose : Shared bus-width defines and FSM encodings for the data-RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam int          INST_ADDR_BUS = 32;
    localparam int          INST_DATA_BUS = 32;

    localparam logic [1:0]  RAM_ARB_IDLE   = 2'd0;
    localparam logic [1:0]  RAM_ARB_ACCESS = 2'd1;
    localparam logic [1:0]  RAM_ARB_RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = RAM_ARB_IDLE,
        ST_ACCESS = RAM_ARB_ACCESS,
        ST_RESP   = RAM_ARB_RESP
    } ram_arb_state_e;

    // One-hot two-way grant to master index.
    function automatic logic win_to_idx(input logic [1:0] win);
        return win[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter_if
// Purpose : Both master request/response channels plus the single-port RAM bus.
// Revision: 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req_i;
    logic          m0_we_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_wdata_i;
    logic          m0_gnt_o;
    logic          m0_rvalid_o;
    logic [DW-1:0] m0_rdata_o;
    logic          m0_err_o;

    logic          m1_req_i;
    logic          m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_wdata_i;
    logic          m1_gnt_o;
    logic          m1_rvalid_o;
    logic [DW-1:0] m1_rdata_o;
    logic          m1_err_o;

    logic          ram_wr_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o;
    logic [DW-1:0] ram_data_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output ram_wr_en_o, ram_addr_o, ram_data_o,
        input  ram_data_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  ram_wr_en_o, ram_addr_o, ram_data_o,
        output ram_data_i
    );

endinterface
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module  : ram_arb_pick
// Purpose : Combinational two-request picker, one-hot result.
//           RAM_ARB_RR_EN selects round-robin; otherwise m0 has fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
module ram_arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

`ifdef RAM_ARB_RR_EN
    // ptr holds the index served last; a tie goes to the other master.
    always_comb begin
        win = 2'b00;
        if (req == 2'b11) begin
            win = ptr ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ptr;

    always_comb begin
        win = 2'b00;
        if (req[0]) begin
            win = 2'b01;
        end else if (req[1]) begin
            win = 2'b10;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Purpose : Serialises core LSU (m0) and UART loader (m1) onto the data RAM.
//           Build option RAM_ARB_RR_EN enables round-robin tie breaking.
// Revision: 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = INST_ADDR_BUS,
    parameter int DW          = INST_DATA_BUS
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    localparam logic [AW-2:0] c_depth_words = (AW-1)'(DEPTH_WORDS);

    ram_arb_state_e  r_state;
    ram_arb_state_e  w_state_nxt;

    logic [1:0]      w_req;
    logic [1:0]      w_win;
    logic [1:0]      w_gnt;
    logic            w_arb_en;
    logic            w_ptr;
    logic            w_access;
    logic            w_resp;
    logic            w_in_range;

    logic            r_owner;
    logic            r_we;
    logic [AW-3:0]   r_word;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_err;

    logic            w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^{bus.m0_addr_i[1:0], bus.m1_addr_i[1:0]};

    assign w_req = {bus.m1_req_i, bus.m0_req_i};

    ram_arb_pick u_pick (
        .req (w_req),
        .ptr (w_ptr),
        .win (w_win)
    );

`ifdef RAM_ARB_RR_EN
    logic r_ptr;

    // Reset value 1 marks m1 as last served, so m0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b1;
        end else if (|w_gnt) begin
            r_ptr <= win_to_idx(w_gnt);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb_en = 1'b1;
                if (|w_req) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // Re-arbitrate while the response is out to keep 2-cycle spacing.
                w_arb_en    = 1'b1;
                w_state_nxt = (|w_req) ? ST_ACCESS : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_gnt    = w_arb_en ? w_win : 2'b00;
    assign w_access = (r_state == ST_ACCESS);
    assign w_resp   = (r_state == ST_RESP);

    assign w_in_range = ({1'b0, r_word} < c_depth_words);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
        end else if (|w_gnt) begin
            r_owner <= win_to_idx(w_gnt);
            if (w_gnt[1]) begin
                r_we    <= bus.m1_we_i;
                r_word  <= bus.m1_addr_i[AW-1:2];
                r_wdata <= bus.m1_wdata_i;
            end else begin
                r_we    <= bus.m0_we_i;
                r_word  <= bus.m0_addr_i[AW-1:2];
                r_wdata <= bus.m0_wdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= DW'(ZERO_WORD);
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_rdata <= (r_we || !w_in_range) ? DW'(ZERO_WORD) : bus.ram_data_i;
            r_err   <= !w_in_range;
        end
    end

    // Write enable is combinational on state so an async reset kills it at once.
    assign bus.ram_wr_en_o = w_access & r_we & w_in_range;
    assign bus.ram_addr_o  = {r_word, 2'b00};
    assign bus.ram_data_o  = r_wdata;

    assign bus.m0_gnt_o    = w_gnt[0];
    assign bus.m1_gnt_o    = w_gnt[1];
    assign bus.m0_rvalid_o = w_resp & ~r_owner;
    assign bus.m1_rvalid_o = w_resp &  r_owner;
    assign bus.m0_rdata_o  = r_owner ? '0 : r_rdata;
    assign bus.m1_rdata_o  = r_owner ? r_rdata : '0;
    assign bus.m0_err_o    = w_resp & ~r_owner & r_err;
    assign bus.m1_err_o    = w_resp &  r_owner & r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_ram_arbiter
// Purpose : Self-checking bench for ram_arbiter with a behavioural RAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst;
    logic tb_clr;

    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(32), .DW(32)) bus ();

    ram_arbiter #(.DEPTH_WORDS(DEPTH), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment RAM: synchronous write, combinational read, known preload.
    logic [31:0] ram [0:DEPTH-1];
    assign bus.ram_data_i = ram[bus.ram_addr_o[13:2]];

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i[11:0]] <= 32'h5A00_0000 | i;
        end else if (bus.ram_wr_en_o) begin
            ram[bus.ram_addr_o[13:2]] <= bus.ram_data_o;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level reference: word-addressed memory, default = preload pattern.
    logic [31:0] ref_mem [int];

    task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err, output logic wr);
        int w;
        w   = int'(addr >> 2);
        err = (w >= DEPTH);
        wr  = we && !err;
        if (we || err)             rd = 32'h0;
        else if (ref_mem.exists(w)) rd = ref_mem[w];
        else                       rd = 32'h5A00_0000 | w;
        if (wr) ref_mem[w] = wd;
    endtask

    function automatic logic gnt_of(input int m);
        return (m != 0) ? bus.m1_gnt_o : bus.m0_gnt_o;
    endfunction
    function automatic logic rvalid_of(input int m);
        return (m != 0) ? bus.m1_rvalid_o : bus.m0_rvalid_o;
    endfunction
    function automatic logic [31:0] rdata_of(input int m);
        return (m != 0) ? bus.m1_rdata_o : bus.m0_rdata_o;
    endfunction
    function automatic logic err_of(input int m);
        return (m != 0) ? bus.m1_err_o : bus.m0_err_o;
    endfunction

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (m == 0) begin
            bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wdata_i = wd;
        end else begin
            bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wdata_i = wd;
        end
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_wr;
    } vec_t;

    typedef struct {
        int          m;
        int          due;
        logic [31:0] rd;
        logic        err;
    } resp_t;

    // Single isolated transaction from IDLE: gnt at N, ACCESS at N+1, rvalid at N+2.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] rd;
        logic        e, w;
        ref_access(v.we, v.addr, v.wd, rd, e, w);
        @(posedge clk); #1;
        drive(v.m, 1'b1, v.we, v.addr, v.wd);
        @(negedge clk);
        chk($sformatf("v%0d gnt", idx), gnt_of(v.m), 1);
        chk($sformatf("v%0d other_gnt", idx), gnt_of(1 - v.m), 0);
        @(posedge clk); #1;
        drive(v.m, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d wr_en", idx), bus.ram_wr_en_o, v.exp_wr);
        chk($sformatf("v%0d ram_addr", idx), bus.ram_addr_o, v.addr & ~32'h3);
        if (v.exp_wr) chk($sformatf("v%0d ram_data", idx), bus.ram_data_o, v.wd);
        @(negedge clk);
        chk($sformatf("v%0d rvalid", idx), rvalid_of(v.m), 1);
        chk($sformatf("v%0d rdata", idx), rdata_of(v.m), v.exp_rd);
        chk($sformatf("v%0d err", idx), err_of(v.m), v.exp_err);
        chk($sformatf("v%0d other_rvalid", idx), rvalid_of(1 - v.m), 0);
        chk($sformatf("v%0d other_rdata", idx), rdata_of(1 - v.m), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        vec_t        v;
        resp_t       pend [$];
        logic [31:0] exp_q [$];
        int          got, lastc, g, rv, found;
        logic        act [2];
        logic        rwe [2];
        logic [31:0] raddr [2];
        logic [31:0] rwd [2];
        int          last_g, last_served, win;
        logic [1:0]  exp_g;
        logic        last_wr;

        tbl[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1};
        tbl[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[2]  = '{1, 1'b1, 32'h0000_0000, 32'h1111_2222, 32'h0,         1'b0, 1'b1};
        tbl[3]  = '{1, 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,         1'b1, 1'b0};
        tbl[4]  = '{1, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222, 1'b0, 1'b0};
        tbl[5]  = '{0, 1'b0, 32'h0000_4000, 32'h0,         32'h0,         1'b1, 1'b0};
        tbl[6]  = '{0, 1'b1, 32'h0000_3FFC, 32'h0BAD_C0DE, 32'h0,         1'b0, 1'b1};
        tbl[7]  = '{1, 1'b0, 32'h0000_3FFC, 32'h0,         32'h0BAD_C0DE, 1'b0, 1'b0};
        tbl[8]  = '{1, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'h0,         1'b0, 1'b1};
        tbl[9]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         32'hAAAA_5555, 1'b0, 1'b0};
        tbl[10] = '{1, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'h0,         1'b1, 1'b0};
        tbl[11] = '{0, 1'b0, 32'h0000_0012, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};

        rst    = 1'b1;
        tb_clr = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 tb_clr = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset gnt%0d", m), gnt_of(m), 0);
            chk($sformatf("reset rvalid%0d", m), rvalid_of(m), 0);
            chk($sformatf("reset err%0d", m), err_of(m), 0);
            chk($sformatf("reset rdata%0d", m), rdata_of(m), 0);
        end
        chk("reset wr_en", bus.ram_wr_en_o, 0);
        chk("reset ram_addr", bus.ram_addr_o, 0);
        chk("reset ram_data", bus.ram_data_o, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        // Reset during ACCESS of an m0 write: no commit, no response.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        @(negedge clk);
        chk("rstmid gnt", bus.m0_gnt_o, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 chk("rstmid wr_en_before", bus.ram_wr_en_o, 1);
        #1 rst = 1'b1;
        #1 chk("rstmid wr_en_drop", bus.ram_wr_en_o, 0);
        chk("rstmid ram_addr", bus.ram_addr_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid rvalid c%0d", c), bus.m0_rvalid_o | bus.m1_rvalid_o, 0);
        end
        v = '{1, 1'b0, 32'h0000_0020, 32'h0, 32'hAAAA_5555, 1'b0, 1'b0};
        run_vec(v, 20);

        // Simultaneous held requests, pointer freshly reset to favour m0.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        got = 0; lastc = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (bus.m0_gnt_o || bus.m1_gnt_o) begin
`ifdef RAM_ARB_RR_EN
                chk($sformatf("tie grant%0d m1", got), bus.m1_gnt_o, got % 2);
`else
                chk($sformatf("tie grant%0d m1", got), bus.m1_gnt_o, 0);
`endif
                if (got > 0) chk($sformatf("tie spacing%0d", got), c - lastc, 2);
                lastc = c;
                got++;
            end
        end
        chk("tie grant count", got, 4);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        found = 0;
        for (int c = 0; c < 6 && found == 0; c++) begin
            @(negedge clk);
            if (bus.m0_gnt_o || bus.m1_gnt_o) begin
                chk("m0 drop then m1 gnt", bus.m1_gnt_o, 1);
                chk("m0 drop no m0 gnt", bus.m0_gnt_o, 0);
                found = 1;
            end
        end
        chk("m1 served after m0 drop", found, 1);
        @(posedge clk); #1 drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        // Back-to-back: m0 keeps re-requesting through rvalid, 8 reads.
        @(posedge clk); #1 drive(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        g = 0; rv = 0; lastc = 0;
        for (int c = 0; c < 40 && rv < 8; c++) begin
            logic [31:0] rd;
            logic        e, w;
            @(negedge clk);
            if (bus.m0_rvalid_o) begin
                chk($sformatf("b2b rsp%0d present", rv), exp_q.size(), 1);
                if (exp_q.size() > 0) chk($sformatf("b2b rdata%0d", rv), bus.m0_rdata_o, exp_q.pop_front());
                rv++;
            end
            if (bus.m0_gnt_o) begin
                ref_access(1'b0, 32'h0000_0100 + 32'(4 * g), 32'h0, rd, e, w);
                exp_q.push_back(rd);
                if (g > 0) chk($sformatf("b2b spacing%0d", g), c - lastc, 2);
                lastc = c;
                g++;
                @(posedge clk); #1;
                if (g < 8) drive(0, 1'b1, 1'b0, 32'h0000_0100 + 32'(4 * g), 32'h0);
                else       drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk("b2b grants", g, 8);
        chk("b2b responses", rv, 8);

        // Randomised traffic against the transaction-level model.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; rwe[m] = 1'b0; raddr[m] = 32'h0; rwd[m] = 32'h0;
        end
        last_g = -10; last_served = 1; last_wr = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (act[m] && $urandom_range(0, 15) == 0) act[m] = 1'b0;
                else if (!act[m] && cyc < 580 && $urandom_range(0, 1) == 1) begin
                    int r;
                    act[m] = 1'b1;
                    rwe[m] = 1'($urandom_range(0, 1));
                    rwd[m] = $urandom;
                    r = $urandom_range(0, 9);
                    if (r < 7)       raddr[m] = 32'($urandom_range(0, 15)) << 2;
                    else if (r == 7) raddr[m] = 32'h0000_3FFC;
                    else if (r == 8) raddr[m] = (32'd4096 + 32'($urandom_range(0, 1000))) << 2;
                    else             raddr[m] = $urandom;
                    raddr[m] = raddr[m] | 32'($urandom_range(0, 3));
                end
                drive(m, act[m], rwe[m], raddr[m], rwd[m]);
            end
            @(negedge clk);
            exp_g = 2'b00;
            if (cyc >= last_g + 2 && (act[0] || act[1])) begin
                resp_t       p;
                logic [31:0] rd;
                logic        e, w;
`ifdef RAM_ARB_RR_EN
                if (act[0] && act[1]) win = (last_served == 0) ? 1 : 0;
`else
                if (act[0] && act[1]) win = 0;
`endif
                else win = act[0] ? 0 : 1;
                exp_g[win] = 1'b1;
                ref_access(rwe[win], raddr[win], rwd[win], rd, e, w);
                p.m = win; p.due = cyc + 2; p.rd = rd; p.err = e;
                pend.push_back(p);
                last_wr = w; last_g = cyc; last_served = win;
                act[win] = 1'b0;
            end
            chk($sformatf("rnd c%0d gnt0", cyc), bus.m0_gnt_o, exp_g[0]);
            chk($sformatf("rnd c%0d gnt1", cyc), bus.m1_gnt_o, exp_g[1]);
            chk($sformatf("rnd c%0d wr_en", cyc), bus.ram_wr_en_o, (cyc == last_g + 1) ? last_wr : 1'b0);
            if (pend.size() > 0 && pend[0].due == cyc) begin
                resp_t p;
                p = pend.pop_front();
                chk($sformatf("rnd c%0d rvalid", cyc), rvalid_of(p.m), 1);
                chk($sformatf("rnd c%0d other_rvalid", cyc), rvalid_of(1 - p.m), 0);
                chk($sformatf("rnd c%0d rdata", cyc), rdata_of(p.m), p.rd);
                chk($sformatf("rnd c%0d err", cyc), err_of(p.m), p.err);
                chk($sformatf("rnd c%0d other_rdata", cyc), rdata_of(1 - p.m), 0);
            end else begin
                chk($sformatf("rnd c%0d idle_rvalid", cyc), bus.m0_rvalid_o | bus.m1_rvalid_o, 0);
            end
            @(posedge clk); #1;
        end
        chk("rnd pending drained", pend.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
